// File: rtl/obuf_a_fifo.sv
// Output-port buffer: captures the arbiter-granted input payload into a small FIFO toward the link.
// Latency: 1 cycle from push edge to head visible on payload_o; no combinational bypass.
// Backpressure: obuf_rdy low when full or power-gated; head held until out_rdy accepts it.
module obuf_a_fifo #(
  parameter int PYLD_W = 17,
  parameter int DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pg_en,
  input  logic [4:0]            arb_gnt,
  input  logic [5*PYLD_W-1:0]   payload_i,
  output logic                  obuf_rdy,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [PYLD_W-1:0]     payload_o,
  output logic                  gnt_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [PYLD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wp;
  logic [AW-1:0]     rp;
  logic [AW:0]       cnt;

  logic              gnt_any;
  logic              gnt_multi;
  logic              push;
  logic              pop;
  logic [PYLD_W-1:0] gnt_pyld;

  // Handshake outputs depend only on held state and pg_en, never on this cycle's grant/out_rdy.
  assign obuf_rdy  = ~pg_en & (cnt != FULL);
  assign out_vld   = ~pg_en & (cnt != '0);
  assign payload_o = mem[rp];

  // A grant with more than one bit set is malformed: it is flagged and never pushed.
  assign gnt_any   = |arb_gnt;
  assign gnt_multi = |(arb_gnt & (arb_gnt - 5'd1));
  assign push      = gnt_any & ~gnt_multi & obuf_rdy;
  assign pop       = out_vld & out_rdy;

  // AND-OR select of the granted input slice.
  always_comb begin
    gnt_pyld = '0;
    for (int i = 0; i < 5; i++) begin
      gnt_pyld = gnt_pyld | (payload_i[i*PYLD_W +: PYLD_W] & {PYLD_W{arb_gnt[i]}});
    end
  end

  // Storage array and write pointer; reset clears contents so payload_o reads zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wp <= '0;
    end else if (push) begin
      mem[wp] <= gnt_pyld;
      wp      <= wp + 1'b1;
    end
  end

  // Read pointer advances on each accepted head entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp <= '0;
    end else if (pop) begin
      rp <= rp + 1'b1;
    end
  end

  // Occupancy: simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Sticky malformed-grant flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_err <= 1'b0;
    end else if (gnt_multi) begin
      gnt_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_obuf_a_fifo.sv
// Directed bench for obuf_a_fifo: fill/drain ordering, full backpressure,
// streaming across pointer wrap, grant errors, power gating and async reset.
module tb_obuf_a_fifo;

  localparam int W = 17;

  logic           clk;
  logic           rst_n;
  logic           pg_en;
  logic [4:0]     arb_gnt;
  logic [5*W-1:0] payload_i;
  logic           obuf_rdy;
  logic           out_vld;
  logic           out_rdy;
  logic [W-1:0]   payload_o;
  logic           gnt_err;

  int n_chk  = 0;
  int n_pass = 0;

  obuf_a_fifo #(.PYLD_W(W), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pg_en     (pg_en),
    .arb_gnt   (arb_gnt),
    .payload_i (payload_i),
    .obuf_rdy  (obuf_rdy),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .payload_o (payload_o),
    .gnt_err   (gnt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; leaves time at 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Grant a single port carrying the given payload.
  task automatic grant(input int port, input logic [W-1:0] val);
    payload_i = '0;
    payload_i[port*W +: W] = val;
    arb_gnt = 5'b00001 << port;
  endtask

  initial begin
    rst_n = 1'b0; pg_en = 1'b0; arb_gnt = '0; payload_i = '0; out_rdy = 1'b0;
    #2;
    chk("rst_obuf_rdy", 32'(obuf_rdy), 32'd1);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_payload_o", 32'(payload_o), 32'd0);
    chk("rst_gnt_err", 32'(gnt_err), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single push from port 2, visible next cycle.
    grant(2, 17'h1ABCD);
    step();
    arb_gnt = '0;
    chk("t1_out_vld", 32'(out_vld), 32'd1);
    chk("t1_payload", 32'(payload_o), 32'h1ABCD);
    chk("t1_obuf_rdy", 32'(obuf_rdy), 32'd1);
    out_rdy = 1'b1;
    step();
    out_rdy = 1'b0;
    chk("t1_drained", 32'(out_vld), 32'd0);

    // Fill to DEPTH from ports 0,1,3,4; 5th grant must be dropped.
    grant(0, 17'd1); step();
    grant(1, 17'd2); step();
    grant(3, 17'd3); step();
    chk("t2_rdy_at3", 32'(obuf_rdy), 32'd1);
    grant(4, 17'd4); step();
    chk("t2_rdy_full", 32'(obuf_rdy), 32'd0);
    grant(2, 17'd5); step();
    chk("t2_rdy_still_full", 32'(obuf_rdy), 32'd0);
    chk("t2_head_kept", 32'(payload_o), 32'd1);
    arb_gnt = '0;
    out_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("t2_vld_%0d", k), 32'(out_vld), 32'd1);
      chk($sformatf("t2_out_%0d", k), 32'(payload_o), 32'(k));
      step();
      if (k == 1) chk("t2_rdy_reassert", 32'(obuf_rdy), 32'd1);
    end
    chk("t2_empty", 32'(out_vld), 32'd0);

    // Streaming: one in, one out per cycle across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      grant(i % 5, 17'(32'h100 + i));
      step();
      chk($sformatf("t3_vld_%0d", i), 32'(out_vld), 32'd1);
      chk($sformatf("t3_out_%0d", i), 32'(payload_o), 32'h100 + 32'(i));
      chk($sformatf("t3_rdy_%0d", i), 32'(obuf_rdy), 32'd1);
    end
    arb_gnt = '0;
    step();
    chk("t3_empty", 32'(out_vld), 32'd0);
    out_rdy = 1'b0;

    // Malformed grant: no push, sticky error.
    payload_i = {5{17'h0F0F0}};
    arb_gnt = 5'b00011;
    step();
    chk("t4_gnt_err", 32'(gnt_err), 32'd1);
    chk("t4_no_push", 32'(out_vld), 32'd0);
    arb_gnt = '0;
    step();
    step();
    chk("t4_gnt_err_sticky", 32'(gnt_err), 32'd1);

    // Power gating freezes a 2-entry FIFO.
    grant(1, 17'h11); step();
    grant(1, 17'h22); step();
    pg_en = 1'b1;
    out_rdy = 1'b1;
    grant(0, 17'h33);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("t5_pg_vld_%0d", c), 32'(out_vld), 32'd0);
      chk($sformatf("t5_pg_rdy_%0d", c), 32'(obuf_rdy), 32'd0);
      step();
    end
    pg_en = 1'b0;
    arb_gnt = '0;
    #1;
    chk("t5_resume_vld", 32'(out_vld), 32'd1);
    chk("t5_resume_0", 32'(payload_o), 32'h11);
    step();
    chk("t5_resume_1", 32'(payload_o), 32'h22);
    step();
    chk("t5_drained", 32'(out_vld), 32'd0);
    out_rdy = 1'b0;

    // Async reset mid-cycle discards contents immediately.
    grant(4, 17'h41); step();
    grant(4, 17'h42); step();
    grant(4, 17'h43); step();
    arb_gnt = '0;
    chk("t6_pre_vld", 32'(out_vld), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_vld", 32'(out_vld), 32'd0);
    chk("t6_rst_payload", 32'(payload_o), 32'd0);
    chk("t6_rst_rdy", 32'(obuf_rdy), 32'd1);
    chk("t6_rst_gnt_err", 32'(gnt_err), 32'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("t6_post_vld", 32'(out_vld), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/obuf_a_fifo.md
# obuf_a_fifo

Per-output-port buffer of the mesh router, directly downstream of the five input-port data buffers and the output arbiter. Each cycle it captures the payload of the input port granted by the arbiter, queues it in a small FIFO, and presents it to the outgoing link with a valid/ready handshake. It also produces the `obuf_rdy` bit that input buffers and arbiter use to decide whether a grant completes a transfer this cycle.

## Interface
- `PYLD_W`, 17, payload width (qos/type/src_pos/data), identical to input-buffer payload width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `pg_en`  in  1  power-gate enable; high = port quiescent
- `arb_gnt`  in  5  one-hot grant from this output's arbiter; bit i selects input port i
- `payload_i`  in  5*PYLD_W  concatenated input-buffer payloads, port i at bits [i*PYLD_W +: PYLD_W]
- `obuf_rdy`  out  1  FIFO can accept a push this cycle
- `out_vld`  out  1  head entry valid toward link
- `out_rdy`  in  1  link accepts head this cycle
- `payload_o`  out  PYLD_W  head entry payload
- `gnt_err`  out  1  sticky: non-one-hot grant seen

## Operation
- Storage: DEPTH×PYLD_W register array, write pointer `wp`, read pointer `rp` (log2(DEPTH) bits, natural wrap), occupancy `cnt` (log2(DEPTH)+1 bits, 0..DEPTH).
- `obuf_rdy = ~pg_en & (cnt != DEPTH)`; combinational from registered state only, never from `arb_gnt`/`out_rdy`.
- push = `|arb_gnt & obuf_rdy`. On push: `mem[wp] <= payload_i` slice selected by `arb_gnt`; `wp <= wp+1`.
- Grant decode: AND-OR mux over the five slices. If `arb_gnt` has >1 bit set: no push, `gnt_err <= 1` (cleared only by reset).
- `out_vld = ~pg_en & (cnt != 0)`. `payload_o = mem[rp]`.
- pop = `out_vld & out_rdy`. On pop: `rp <= rp+1`.
- `cnt` next = cnt + push − pop; simultaneous push and pop leaves `cnt` unchanged and is legal at any occupancy 1..DEPTH−1; at cnt==DEPTH push is impossible (obuf_rdy low), pop allowed; at cnt==0 pop impossible, push allowed.
- No bypass: an empty FIFO does not forward `payload_i` combinationally.
- `pg_en` high: no push, no pop, contents and pointers held; on `pg_en` fall, `out_vld`/`obuf_rdy` resume from held `cnt` same cycle.
- Reset: `wp`, `rp`, `cnt`, `gnt_err` = 0; memory cleared to 0. Outputs during/after reset: `obuf_rdy` = 1 (if `pg_en` low), `out_vld` = 0, `payload_o` = 0, `gnt_err` = 0. Reset asserted mid-operation discards all entries immediately.

## Timing
- Push at edge N → entry visible on `payload_o` with `out_vld`=1 after edge N (cycle N+1) when FIFO was empty; minimum latency 1 cycle.
- Pop at edge N → next entry (if any) on `payload_o` in cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- `obuf_rdy` deasserts in the cycle after the push that makes cnt==DEPTH; reasserts the cycle after the pop that leaves cnt==DEPTH−1.
- Upstream contract: input buffer frees its slot iff `arb_gnt[i] & obuf_rdy` that cycle; this block must push exactly then.
- All outputs are functions of registers and `pg_en` only.

## Test plan
- Reset then `arb_gnt`=5'b00100, port2 payload 17'h1ABCD, `out_rdy`=0 → next cycle `out_vld`=1, `payload_o`=17'h1ABCD, cnt=1, `obuf_rdy`=1.
- Four pushes from ports 0,1,3,4 (values 1,2,3,4), `out_rdy`=0 → `obuf_rdy`=0 after 4th; 5th grant ignored; then `out_rdy`=1 four cycles → outputs 1,2,3,4 in order, `out_vld`=0 after.
- Continuous grant + `out_rdy`=1 for 10 cycles with incrementing payloads → one output per cycle, 1-cycle lag, cnt stays 1, no loss across pointer wrap.
- `arb_gnt`=5'b00011 → no push, `gnt_err`=1 and stays 1 until `rst_n` low.
- FIFO holding 2 entries, `pg_en`=1 for 5 cycles with grants and `out_rdy`=1 → `out_vld`=0, `obuf_rdy`=0, no change; `pg_en`=0 → same 2 entries drain in order.
- Fill 3 entries, pulse `rst_n` low mid-cycle → immediately `out_vld`=0, `payload_o`=0, cnt=0, `obuf_rdy`=1.
